// File: rtl/tt_pgfarley_accum_alu.sv
// tt_pgfarley_accum_alu
//   Adder / per-channel accumulator datapath with a single registered result
//   stage and valid/ready handshakes on both sides.
//
//   Commands (in_op): 00 ADD  result = a + b            (accumulators untouched)
//                     01 ACC  acc[ch] = acc[ch] + a, result = new acc[ch]
//                     10 CLR  acc[ch] = 0, result = 0
//                     11 READ result = acc[ch]
//   SATURATE=0 wraps modulo 2^WIDTH; SATURATE=1 clamps to all-ones.
//   out_carry is always the raw unsigned carry of the sum, even when clamped.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           command handshake (in_ready = !out_valid | out_ready)
//   in_op, in_ch, in_a, in_b    command, channel, operands
//   out_valid/out_ready         result handshake
//   out_result, out_carry, out_ch  registered result, carry, command channel

module tt_pgfarley_accum_alu #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [CW-1:0]    in_ch,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic [CW-1:0]    out_ch
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic [CHANNELS-1:0][WIDTH-1:0] acc_q, acc_d;
    logic                           out_valid_q, out_valid_d;
    logic [WIDTH-1:0]               out_result_q, out_result_d;
    logic                           out_carry_q, out_carry_d;
    logic [CW-1:0]                  out_ch_q, out_ch_d;

    logic             accept;
    logic [CW-1:0]    ch_sel;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sum_fit;

    // No bubble: a stalled result that is being taken this cycle frees the slot.
    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // With a single channel the select bit is meaningless; pin it to entry 0.
    assign ch_sel = (CHANNELS > 1) ? in_ch : '0;

    // One shared adder: ADD uses b as the second operand, ACC uses the
    // current accumulator (the registered value, so back-to-back ACC chains
    // naturally through acc_q with no forwarding needed).
    assign addend  = (in_op == OP_ADD) ? in_b : acc_q[ch_sel];
    assign sum     = {1'b0, in_a} + {1'b0, addend};
    assign sum_fit = ((SATURATE != 0) && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

    always_comb begin
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_carry_d  = out_carry_q;
        out_ch_d     = out_ch_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_ch_d    = ch_sel;
            case (in_op)
                OP_ADD: begin
                    out_result_d = sum_fit;
                    out_carry_d  = sum[WIDTH];
                    out_ch_d     = '0;
                end
                OP_ACC: begin
                    acc_d[ch_sel] = sum_fit;
                    out_result_d  = sum_fit;
                    out_carry_d   = sum[WIDTH];
                end
                OP_CLR: begin
                    acc_d[ch_sel] = '0;
                    out_result_d  = '0;
                    out_carry_d   = 1'b0;
                end
                default: begin // OP_READ
                    out_result_d = acc_q[ch_sel];
                    out_carry_d  = 1'b0;
                end
            endcase
        end else if (out_ready) begin
            // Result consumed and nothing new arriving; data stays, valid drops.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_ch_q     <= '0;
        end else begin
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_carry_q  <= out_carry_d;
            out_ch_q     <= out_ch_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_carry  = out_carry_q;
    assign out_ch     = out_ch_q;

endmodule

// File: tb/tb_tt_pgfarley_accum_alu.sv
// Bench for tt_pgfarley_accum_alu: one wrapping and one saturating instance
// share the same stimulus; a per-instance behavioural model predicts the
// result register contents and in_ready every cycle.

module tb_tt_pgfarley_accum_alu;

    localparam int W    = 8;
    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int MAXV = 1 << W;

    localparam logic [1:0] ADD = 2'b00, ACC = 2'b01, CLR = 2'b10, RD = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [1:0]    in_op;
    logic [CW-1:0] in_ch;
    logic [W-1:0]  in_a, in_b;
    logic          out_ready;

    logic          irdy [2];
    logic          ov   [2];
    logic [W-1:0]  ores [2];
    logic          ocar [2];
    logic [CW-1:0] och  [2];

    always #5 clk = ~clk;

    tt_pgfarley_accum_alu #(.WIDTH(W), .CHANNELS(NCH), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]),
        .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
        .out_valid(ov[0]), .out_ready(out_ready), .out_result(ores[0]),
        .out_carry(ocar[0]), .out_ch(och[0])
    );

    tt_pgfarley_accum_alu #(.WIDTH(W), .CHANNELS(NCH), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]),
        .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b),
        .out_valid(ov[1]), .out_ready(out_ready), .out_result(ores[1]),
        .out_carry(ocar[1]), .out_ch(och[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = wrap, 1 = saturate.
    int m_acc [2][NCH];
    int m_v   [2];
    int m_res [2];
    int m_car [2];
    int m_ch  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fit(input int s, input int sat);
        if (s >= MAXV) return sat ? MAXV - 1 : s - MAXV;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NCH; c++) m_acc[i][c] = 0;
            m_v[i] = 0; m_res[i] = 0; m_car[i] = 0; m_ch[i] = 0;
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [1:0] op,
                              input int ch, input int a, input int b, input bit ordy);
        int s;
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (v && (m_v[i] == 0 || ordy)) begin
                m_v[i]  = 1;
                m_ch[i] = ch;
                case (op)
                    ADD: begin
                        s = a + b;
                        m_res[i] = fit(s, i); m_car[i] = (s >= MAXV); m_ch[i] = 0;
                    end
                    ACC: begin
                        s = m_acc[i][ch] + a;
                        m_acc[i][ch] = fit(s, i);
                        m_res[i] = m_acc[i][ch]; m_car[i] = (s >= MAXV);
                    end
                    CLR: begin
                        m_acc[i][ch] = 0; m_res[i] = 0; m_car[i] = 0;
                    end
                    default: begin
                        m_res[i] = m_acc[i][ch]; m_car[i] = 0;
                    end
                endcase
            end else if (ordy) begin
                m_v[i] = 0;
            end
        end
    endtask

    // Called at a negedge: drive, check in_ready, clock once, check outputs.
    task automatic step(input bit r, input bit v, input logic [1:0] op,
                        input int ch, input int a, input int b, input bit ordy);
        rst = r; in_valid = v; in_op = op; in_ch = CW'(ch);
        in_a = W'(a); in_b = W'(b); out_ready = ordy;
        #1;
        if (!r) begin
            for (int i = 0; i < 2; i++)
                chk($sformatf("in_ready[%0d]", i), 32'(irdy[i]), 32'(m_v[i] == 0 || ordy));
        end
        @(posedge clk);
        model_edge(r, v, op, ch, a, b, ordy);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("out_valid[%0d]", i),  32'(ov[i]),   32'(m_v[i]));
            chk($sformatf("out_result[%0d]", i), 32'(ores[i]), 32'(m_res[i]));
            chk($sformatf("out_carry[%0d]", i),  32'(ocar[i]), 32'(m_car[i]));
            chk($sformatf("out_ch[%0d]", i),     32'(och[i]),  32'(m_ch[i]));
        end
    endtask

    task automatic cmd(input logic [1:0] op, input int ch, input int a, input int b);
        step(1'b0, 1'b1, op, ch, a, b, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = ADD; in_ch = '0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        step(1'b1, 1'b0, ADD, 0, 0, 0, 1'b0);
        step(1'b1, 1'b0, ADD, 0, 0, 0, 1'b0);

        // Reset state
        chk("rst_valid", 32'(ov[0]), 32'd0);
        chk("rst_result", 32'(ores[0]), 32'd0);
        #1 chk("rst_in_ready", 32'(irdy[0]), 32'd1);
        @(negedge clk);

        // ADD wrap / saturate, single-cycle latency
        cmd(ADD, 3, 200, 100);
        chk("add_wrap_res", 32'(ores[0]), 32'd44);
        chk("add_wrap_car", 32'(ocar[0]), 32'd1);
        chk("add_sat_res",  32'(ores[1]), 32'd255);
        chk("add_sat_car",  32'(ocar[1]), 32'd1);
        chk("add_ch_zero",  32'(och[0]),  32'd0);
        cmd(ADD, 0, 3, 4);
        chk("add_small_sat", 32'(ores[1]), 32'd7);
        chk("add_small_car", 32'(ocar[1]), 32'd0);

        // ACC streaming on ch2
        for (int k = 1; k <= 30; k++) begin
            cmd(ACC, 2, 10, 0);
            if (k == 25) chk("acc25_wrap", 32'(ores[0]), 32'd250);
            if (k == 26) begin
                chk("acc26_wrap", 32'(ores[0]), 32'd4);
                chk("acc26_car",  32'(ocar[0]), 32'd1);
                chk("acc26_sat",  32'(ores[1]), 32'd255);
            end
        end
        cmd(RD, 1, 0, 0);
        chk("ch1_untouched", 32'(ores[0]), 32'd0);

        // Backpressure: one ACC, then 5 stalled cycles with a command waiting
        cmd(CLR, 0, 0, 0);
        cmd(ACC, 0, 5, 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, ACC, 0, 9, 0, 1'b0);
            chk("stall_hold", 32'(ores[0]), 32'd5);
        end
        step(1'b0, 1'b0, ACC, 0, 9, 0, 1'b0);
        step(1'b0, 1'b0, ACC, 0, 9, 0, 1'b1);
        chk("stall_drain", 32'(ov[0]), 32'd0);
        cmd(RD, 0, 0, 0);
        chk("no_double_acc", 32'(ores[0]), 32'd5);

        // CLR / READ interleave
        cmd(ACC, 1, 7, 0);
        chk("il_acc", 32'(ores[0]), 32'd7);
        cmd(CLR, 1, 0, 0);
        chk("il_clr", 32'(ores[0]), 32'd0);
        cmd(RD, 1, 0, 0);
        chk("il_rd", 32'(ores[0]), 32'd0);

        // Random mix
        for (int n = 0; n < 10000; n++) begin
            step(1'b0, ($urandom_range(3, 0) != 0), 2'($urandom_range(3, 0)),
                 int'($urandom_range(NCH - 1, 0)), int'($urandom_range(MAXV - 1, 0)),
                 int'($urandom_range(MAXV - 1, 0)), ($urandom_range(9, 0) < 7));
        end

        // Mid-stream reset while a result may be pending
        step(1'b0, 1'b1, ACC, 3, 77, 0, 1'b0);
        step(1'b1, 1'b1, ACC, 3, 1, 0, 1'b0);
        step(1'b1, 1'b1, ACC, 3, 1, 0, 1'b0);
        chk("midrst_valid", 32'(ov[0]), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            cmd(RD, c, 0, 0);
            chk($sformatf("midrst_rd%0d", c), 32'(ores[0]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
